cpu_debug_ocimem_arbiter: RTL and testbench
===========================================

Name: cpu_debug_ocimem_arbiter

Overview:
- Sysclk-domain controller that shares the CPU's on-chip debug monitor RAM between two requesters.
- Requester 1: the JTAG debug slave path. Its take_action_ocimem strobes and the jdo fields are decoded upstream into jtag_* pulses.
- Requester 2: the CPU's Avalon debug memory slave port.
- The block serialises accesses, owns the auto-incrementing JTAG address register (MonAReg) and the JTAG read-data register (MonDReg). MonDReg feeds back into the debug slave TCK shift register.

Parameters:
ADDR_W, 8, word address width of the monitor RAM
DATA_W, 32, data width
RD_LAT, 1, RAM read latency in cycles; legal range 1..3

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
jtag_load_addr  in  1  one-cycle pulse; load MonAReg from jtag_addr
jtag_addr  in  ADDR_W  address field from jdo
jtag_rd  in  1  one-cycle pulse; JTAG read request
jtag_wr  in  1  one-cycle pulse; JTAG write request
jtag_wdata  in  DATA_W  write data from jdo
jtag_autoinc  in  1  increment MonAReg after each JTAG access
jtag_done  out  1  one-cycle pulse when a JTAG access completes
jtag_overrun  out  1  sticky; a request arrived while one was already pending
mon_dreg  out  DATA_W  MonDReg; JTAG read result
mon_areg  out  ADDR_W  MonAReg
av_read  in  1  Avalon read
av_write  in  1  Avalon write
av_address  in  ADDR_W  Avalon word address
av_writedata  in  DATA_W  Avalon write data
av_byteenable  in  DATA_W/8  Avalon byte enables
av_debugaccess  in  1  write permitted only when high
av_waitrequest  out  1  Avalon waitrequest
av_readdata  out  DATA_W  Avalon read data
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  DATA_W  RAM write data
ram_be  out  DATA_W/8  RAM byte enables
ram_wr  out  1  RAM write enable
ram_rd  out  1  RAM read enable
ram_rdata  in  DATA_W  RAM read data, valid RD_LAT cycles after ram_rd

Behaviour:
- Interface: one clock, clk; reset_n is asynchronous, active-low.
- Reset values: state=IDLE, av_waitrequest=1, jtag_done=0, jtag_overrun=0, mon_dreg=0, mon_areg=0, ram_wr=0, ram_rd=0, ram_addr/wdata/be=0, av_readdata=0, jtag pending=0, last_grant=JTAG.
- Reset asserted mid-operation: aborts the access, no RAM write, pending cleared, return to IDLE.
- JTAG request capture:
  - jtag_rd or jtag_wr sets pend (type + wdata latched).
  - A pulse while pend=1 sets jtag_overrun (sticky until reset); the new request is dropped.
  - jtag_rd and jtag_wr in the same cycle: treated as a write.
- FSM states: IDLE, AV_ACC, JT_ACC, RD_WAIT, AV_DONE.
  - IDLE, only one requester (av_read|av_write, or pend): grant it.
  - IDLE, both requesting: grant the one not in last_grant (round-robin); last_grant updates on every grant.
  - AV_ACC / JT_ACC: RAM outputs are registered from the granted source for exactly one cycle.
    - AV_ACC: ram_addr=av_address, ram_be=av_byteenable.
    - JT_ACC: ram_addr=mon_areg, ram_be=all ones.
  - Write from AV_ACC: ram_wr=1 only if av_debugaccess=1; otherwise suppressed but the access still completes. av_waitrequest=0 in the next cycle (AV_DONE), then IDLE.
  - Read: ram_rd=1, then RD_WAIT for RD_LAT cycles. ram_rdata is captured into av_readdata (Avalon) or mon_dreg (JTAG). Then AV_DONE, or jtag_done=1, then IDLE.
- Avalon latency from the request cycle in IDLE to the av_waitrequest=0 cycle:
  - write: 2 cycles;
  - read: 2+RD_LAT cycles.
- av_waitrequest is low for exactly one cycle per access. Avalon must hold its inputs stable while waitrequest is high.
- JTAG latency from the request pulse to jtag_done:
  - write: 2 cycles;
  - read: 2+RD_LAT cycles;
  - plus the duration of any Avalon access already in flight.
- pend clears in the same cycle jtag_done is asserted.
- MonAReg:
  - jtag_load_addr loads jtag_addr.
  - On jtag_done with jtag_autoinc=1: increments modulo 2^ADDR_W (all-ones wraps to 0).
  - Load and increment in the same cycle: load wins.
- A new request is accepted in the cycle after DONE. There are no back-to-back grants without passing through IDLE.

Decomposition:
- Package cpu_debug_ocimem_pkg: state enum; GRANT_JTAG/GRANT_AV constants; RD_LAT legal-range check constant.
- Sub-module cpu_debug_ocimem_rr_arb: 2-way round-robin arbiter holding last_grant.
- FSM, capture logic and MonAReg/MonDReg live in the top module.

Test Plan:
- RD_LAT=1. Avalon write addr 0x10, data 0xDEADBEEF, debugaccess=1 → ram_wr for one cycle with addr 0x10; av_waitrequest low on cycle 2. Avalon read addr 0x10 → av_readdata=0xDEADBEEF, waitrequest low on cycle 3.
- Avalon write with av_debugaccess=0 → ram_wr never asserted, access still completes; a subsequent read returns the old value.
- jtag_load_addr 0xFE, autoinc=1, three jtag_wr of 1/2/3 → RAM 0xFE=1, 0xFF=2, 0x00=3; mon_areg=0x01 at the end.
- jtag_rd pulsed in the same cycle as av_read, last_grant=JTAG → Avalon served first; JTAG jtag_done follows and mon_dreg = RAM data. Repeat with last_grant=AV → JTAG served first.
- Second jtag_wr while pend=1 → jtag_overrun=1 and stays set; only the first write reaches the RAM.
- reset_n dropped during RD_WAIT → all outputs at reset values immediately; no jtag_done; the next request after reset completes normally.

Source files
------------

// File: rtl/cpu_debug_ocimem_pkg.sv
// Shared types and constants for the OCI debug-memory arbiter.
// The arbiter serialises JTAG and Avalon accesses to the monitor RAM.
package cpu_debug_ocimem_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_AV_ACC,
        S_JT_ACC,
        S_RD_WAIT,
        S_AV_DONE
    } state_t;

    localparam logic GRANT_JTAG = 1'b0;
    localparam logic GRANT_AV   = 1'b1;

    localparam int unsigned RD_LAT_MIN = 1;
    localparam int unsigned RD_LAT_MAX = 3;

    function automatic logic rd_lat_ok(input int unsigned lat);
        return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
    endfunction

endpackage

// File: rtl/cpu_debug_ocimem_rr_arb.sv
// Two-way round-robin arbiter between the JTAG and Avalon requesters.
// Grants are combinational; last_grant only advances when a grant is issued.
module cpu_debug_ocimem_rr_arb
    import cpu_debug_ocimem_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic grant_en,
    input  logic req_av,
    input  logic req_jt,
    output logic gnt_av,
    output logic gnt_jt
);

    logic last_grant_q;
    logic last_grant_d;

    always_comb begin
        gnt_av       = 1'b0;
        gnt_jt       = 1'b0;
        last_grant_d = last_grant_q;
        if (grant_en) begin
            if (req_av && req_jt) begin
                if (last_grant_q == GRANT_JTAG) gnt_av = 1'b1;
                else                            gnt_jt = 1'b1;
            end else if (req_av) begin
                gnt_av = 1'b1;
            end else if (req_jt) begin
                gnt_jt = 1'b1;
            end
            if (gnt_av)      last_grant_d = GRANT_AV;
            else if (gnt_jt) last_grant_d = GRANT_JTAG;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) last_grant_q <= GRANT_JTAG;
        else          last_grant_q <= last_grant_d;
    end

endmodule

// File: rtl/cpu_debug_ocimem_arbiter.sv
// Shares the CPU debug monitor RAM between the JTAG debug slave and the Avalon
// debug port; owns MonAReg (auto-incrementing address) and MonDReg (read data).
module cpu_debug_ocimem_arbiter
    import cpu_debug_ocimem_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RD_LAT = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  jtag_load_addr,
    input  logic [ADDR_W-1:0]     jtag_addr,
    input  logic                  jtag_rd,
    input  logic                  jtag_wr,
    input  logic [DATA_W-1:0]     jtag_wdata,
    input  logic                  jtag_autoinc,
    output logic                  jtag_done,
    output logic                  jtag_overrun,
    output logic [DATA_W-1:0]     mon_dreg,
    output logic [ADDR_W-1:0]     mon_areg,
    input  logic                  av_read,
    input  logic                  av_write,
    input  logic [ADDR_W-1:0]     av_address,
    input  logic [DATA_W-1:0]     av_writedata,
    input  logic [DATA_W/8-1:0]   av_byteenable,
    input  logic                  av_debugaccess,
    output logic                  av_waitrequest,
    output logic [DATA_W-1:0]     av_readdata,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic [DATA_W-1:0]     ram_wdata,
    output logic [DATA_W/8-1:0]   ram_be,
    output logic                  ram_wr,
    output logic                  ram_rd,
    input  logic [DATA_W-1:0]     ram_rdata
);

    if (!rd_lat_ok(RD_LAT)) begin : g_bad_rd_lat
        $error("cpu_debug_ocimem_arbiter: RD_LAT must be within 1..3");
    end

    localparam logic [1:0] RD_LAT_L = 2'(RD_LAT);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
    logic [DATA_W/8-1:0] ram_be_q, ram_be_d;
    logic                ram_wr_q, ram_wr_d;
    logic                ram_rd_q, ram_rd_d;
    logic                av_wait_q, av_wait_d;
    logic [DATA_W-1:0]   av_rdata_q, av_rdata_d;
    logic                jt_done_q, jt_done_d;
    logic                jt_ovr_q, jt_ovr_d;
    logic [DATA_W-1:0]   mon_dreg_q, mon_dreg_d;
    logic [ADDR_W-1:0]   mon_areg_q, mon_areg_d;
    logic                pend_q, pend_d;
    logic                pend_wr_q, pend_wr_d;
    logic [DATA_W-1:0]   pend_wdata_q, pend_wdata_d;
    logic                src_av_q, src_av_d;
    logic [1:0]          cnt_q, cnt_d;

    logic                jt_pulse;
    logic                jt_is_wr;
    logic [DATA_W-1:0]   jt_wdata;
    logic                gnt_av, gnt_jt;

    assign jt_pulse = jtag_rd | jtag_wr;
    // A fresh pulse is granted in its own cycle, so it bypasses the pending latch.
    assign jt_is_wr = pend_q ? pend_wr_q    : jtag_wr;
    assign jt_wdata = pend_q ? pend_wdata_q : jtag_wdata;

    cpu_debug_ocimem_rr_arb u_rr_arb (
        .clk      (clk),
        .reset_n  (reset_n),
        .grant_en (state_q == S_IDLE),
        .req_av   (av_read | av_write),
        .req_jt   (pend_q | jt_pulse),
        .gnt_av   (gnt_av),
        .gnt_jt   (gnt_jt)
    );

    always_comb begin
        state_d      = state_q;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;
        ram_be_d     = ram_be_q;
        ram_wr_d     = 1'b0;
        ram_rd_d     = 1'b0;
        av_wait_d    = 1'b1;
        av_rdata_d   = av_rdata_q;
        jt_done_d    = 1'b0;
        jt_ovr_d     = jt_ovr_q | (jt_pulse & pend_q);
        mon_dreg_d   = mon_dreg_q;
        mon_areg_d   = mon_areg_q;
        pend_d       = pend_q;
        pend_wr_d    = pend_wr_q;
        pend_wdata_d = pend_wdata_q;
        src_av_d     = src_av_q;
        cnt_d        = cnt_q;

        if (jt_pulse && !pend_q) begin
            pend_d       = 1'b1;
            pend_wr_d    = jtag_wr;
            pend_wdata_d = jtag_wdata;
        end

        unique case (state_q)
            S_IDLE: begin
                if (gnt_av) begin
                    state_d     = S_AV_ACC;
                    src_av_d    = 1'b1;
                    ram_addr_d  = av_address;
                    ram_be_d    = av_byteenable;
                    ram_wdata_d = av_writedata;
                    ram_wr_d    = av_write & av_debugaccess;
                    ram_rd_d    = ~av_write;
                end else if (gnt_jt) begin
                    state_d     = S_JT_ACC;
                    src_av_d    = 1'b0;
                    ram_addr_d  = mon_areg_q;
                    ram_be_d    = '1;
                    ram_wdata_d = jt_wdata;
                    ram_wr_d    = jt_is_wr;
                    ram_rd_d    = ~jt_is_wr;
                end
            end
            S_AV_ACC: begin
                if (ram_rd_q) begin
                    state_d = S_RD_WAIT;
                    cnt_d   = 2'd1;
                end else begin
                    state_d   = S_AV_DONE;
                    av_wait_d = 1'b0;
                end
            end
            S_JT_ACC: begin
                if (ram_rd_q) begin
                    state_d = S_RD_WAIT;
                    cnt_d   = 2'd1;
                end else begin
                    state_d   = S_IDLE;
                    jt_done_d = 1'b1;
                end
            end
            S_RD_WAIT: begin
                if (cnt_q == RD_LAT_L) begin
                    if (src_av_q) begin
                        av_rdata_d = ram_rdata;
                        av_wait_d  = 1'b0;
                        state_d    = S_AV_DONE;
                    end else begin
                        mon_dreg_d = ram_rdata;
                        jt_done_d  = 1'b1;
                        state_d    = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            S_AV_DONE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase

        if (jt_done_d) pend_d = 1'b0;

        // Increment alongside jtag_done so a grant in the done cycle sees the new address.
        if (jtag_load_addr)                mon_areg_d = jtag_addr;
        else if (jt_done_d && jtag_autoinc) mon_areg_d = mon_areg_q + ADDR_W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            ram_be_q     <= '0;
            ram_wr_q     <= 1'b0;
            ram_rd_q     <= 1'b0;
            av_wait_q    <= 1'b1;
            av_rdata_q   <= '0;
            jt_done_q    <= 1'b0;
            jt_ovr_q     <= 1'b0;
            mon_dreg_q   <= '0;
            mon_areg_q   <= '0;
            pend_q       <= 1'b0;
            pend_wr_q    <= 1'b0;
            pend_wdata_q <= '0;
            src_av_q     <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            ram_be_q     <= ram_be_d;
            ram_wr_q     <= ram_wr_d;
            ram_rd_q     <= ram_rd_d;
            av_wait_q    <= av_wait_d;
            av_rdata_q   <= av_rdata_d;
            jt_done_q    <= jt_done_d;
            jt_ovr_q     <= jt_ovr_d;
            mon_dreg_q   <= mon_dreg_d;
            mon_areg_q   <= mon_areg_d;
            pend_q       <= pend_d;
            pend_wr_q    <= pend_wr_d;
            pend_wdata_q <= pend_wdata_d;
            src_av_q     <= src_av_d;
            cnt_q        <= cnt_d;
        end
    end

    assign jtag_done      = jt_done_q;
    assign jtag_overrun   = jt_ovr_q;
    assign mon_dreg       = mon_dreg_q;
    assign mon_areg       = mon_areg_q;
    assign av_waitrequest = av_wait_q;
    assign av_readdata    = av_rdata_q;
    assign ram_addr       = ram_addr_q;
    assign ram_wdata      = ram_wdata_q;
    assign ram_be         = ram_be_q;
    assign ram_wr         = ram_wr_q;
    assign ram_rd         = ram_rd_q;

endmodule

// File: tb/tb_cpu_debug_ocimem_arbiter.sv
// Directed bench for cpu_debug_ocimem_arbiter with a behavioural RD_LAT=1 RAM.
module tb_cpu_debug_ocimem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        jtag_load_addr = 1'b0;
    logic [7:0]  jtag_addr = '0;
    logic        jtag_rd = 1'b0;
    logic        jtag_wr = 1'b0;
    logic [31:0] jtag_wdata = '0;
    logic        jtag_autoinc = 1'b0;
    logic        jtag_done;
    logic        jtag_overrun;
    logic [31:0] mon_dreg;
    logic [7:0]  mon_areg;
    logic        av_read = 1'b0;
    logic        av_write = 1'b0;
    logic [7:0]  av_address = '0;
    logic [31:0] av_writedata = '0;
    logic [3:0]  av_byteenable = '0;
    logic        av_debugaccess = 1'b0;
    logic        av_waitrequest;
    logic [31:0] av_readdata;
    logic [7:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [3:0]  ram_be;
    logic        ram_wr;
    logic        ram_rd;
    logic [31:0] ram_rdata = '0;

    logic [31:0] mem [0:255];
    int          wr_cnt = 0;
    int          tests = 0;
    int          failed = 0;

    always #5 clk = ~clk;

    cpu_debug_ocimem_arbiter #(.ADDR_W(8), .DATA_W(32), .RD_LAT(1)) dut (
        .clk(clk), .reset_n(reset_n),
        .jtag_load_addr(jtag_load_addr), .jtag_addr(jtag_addr),
        .jtag_rd(jtag_rd), .jtag_wr(jtag_wr), .jtag_wdata(jtag_wdata),
        .jtag_autoinc(jtag_autoinc), .jtag_done(jtag_done),
        .jtag_overrun(jtag_overrun), .mon_dreg(mon_dreg), .mon_areg(mon_areg),
        .av_read(av_read), .av_write(av_write), .av_address(av_address),
        .av_writedata(av_writedata), .av_byteenable(av_byteenable),
        .av_debugaccess(av_debugaccess), .av_waitrequest(av_waitrequest),
        .av_readdata(av_readdata), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_be(ram_be), .ram_wr(ram_wr), .ram_rd(ram_rd), .ram_rdata(ram_rdata)
    );

    function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0] be);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        if (ram_wr) begin
            mem[ram_addr] <= be_merge(mem[ram_addr], ram_wdata, ram_be);
            wr_cnt <= wr_cnt + 1;
        end
        if (ram_rd) ram_rdata <= mem[ram_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic av_access(input logic wr, input logic [7:0] a, input logic [31:0] d,
                             input logic dbg, output int lat, output logic [31:0] rd);
        av_write = wr; av_read = ~wr; av_address = a; av_writedata = d;
        av_byteenable = 4'hF; av_debugaccess = dbg;
        lat = 99;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (!av_waitrequest) begin
                lat = i;
                break;
            end
        end
        rd = av_readdata;
        av_write = 1'b0; av_read = 1'b0; av_debugaccess = 1'b0;
        tick();
        check("av_wait_one_cycle", 32'(av_waitrequest), 32'd1);
    endtask

    task automatic jt_access(input logic wr, input logic [31:0] d, output int lat);
        jtag_wr = wr; jtag_rd = ~wr; jtag_wdata = d;
        lat = 99;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 1) begin
                jtag_wr = 1'b0; jtag_rd = 1'b0;
            end
            if (jtag_done) begin
                lat = i;
                break;
            end
        end
        tick();
    endtask

    task automatic jt_load(input logic [7:0] a);
        jtag_load_addr = 1'b1; jtag_addr = a;
        tick();
        jtag_load_addr = 1'b0;
        check("mon_areg_load", 32'(mon_areg), 32'(a));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, av_lat, jt_lat, w0;
        logic [31:0] rd;

        repeat (2) @(posedge clk);
        #1;
        check("rst_waitreq", 32'(av_waitrequest), 32'd1);
        check("rst_done", 32'(jtag_done), 32'd0);
        check("rst_overrun", 32'(jtag_overrun), 32'd0);
        check("rst_dreg", mon_dreg, 32'd0);
        check("rst_areg", 32'(mon_areg), 32'd0);
        check("rst_ram_wr", 32'(ram_wr), 32'd0);
        check("rst_ram_rd", 32'(ram_rd), 32'd0);
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        check("rst_readdata", av_readdata, 32'd0);
        reset_n = 1'b1;
        tick();

        // Avalon write, cycle by cycle
        av_write = 1'b1; av_address = 8'h10; av_writedata = 32'hDEADBEEF;
        av_byteenable = 4'hF; av_debugaccess = 1'b1;
        tick();
        check("avw_c1_ram_wr", 32'(ram_wr), 32'd1);
        check("avw_c1_ram_addr", 32'(ram_addr), 32'h10);
        check("avw_c1_ram_wdata", ram_wdata, 32'hDEADBEEF);
        check("avw_c1_ram_be", 32'(ram_be), 32'hF);
        check("avw_c1_waitreq", 32'(av_waitrequest), 32'd1);
        tick();
        check("avw_c2_waitreq", 32'(av_waitrequest), 32'd0);
        check("avw_c2_ram_wr", 32'(ram_wr), 32'd0);
        av_write = 1'b0; av_debugaccess = 1'b0;
        tick();
        check("avw_c3_waitreq", 32'(av_waitrequest), 32'd1);
        check("avw_mem", mem[8'h10], 32'hDEADBEEF);
        check("avw_wr_cnt", 32'(wr_cnt), 32'd1);

        av_access(1'b0, 8'h10, 32'h0, 1'b0, lat, rd);
        check("avr_lat", 32'(lat), 32'd3);
        check("avr_data", rd, 32'hDEADBEEF);

        // Write without debugaccess is suppressed but completes
        w0 = wr_cnt;
        av_access(1'b1, 8'h10, 32'h12345678, 1'b0, lat, rd);
        check("avw_nodbg_lat", 32'(lat), 32'd2);
        check("avw_nodbg_no_wr", 32'(wr_cnt - w0), 32'd0);
        av_access(1'b0, 8'h10, 32'h0, 1'b0, lat, rd);
        check("avr_after_nodbg", rd, 32'hDEADBEEF);

        // JTAG writes with autoincrement across the wrap
        jt_load(8'hFE);
        jtag_autoinc = 1'b1;
        jt_access(1'b1, 32'd1, lat);
        check("jtw1_lat", 32'(lat), 32'd2);
        jt_access(1'b1, 32'd2, lat);
        check("jtw2_lat", 32'(lat), 32'd2);
        jt_access(1'b1, 32'd3, lat);
        check("jtw3_lat", 32'(lat), 32'd2);
        check("jtw_mem_fe", mem[8'hFE], 32'd1);
        check("jtw_mem_ff", mem[8'hFF], 32'd2);
        check("jtw_mem_00", mem[8'h00], 32'd3);
        check("jtw_areg_wrap", 32'(mon_areg), 32'h01);

        // Simultaneous requests, last grant JTAG: Avalon first
        jtag_autoinc = 1'b0;
        jt_load(8'hFE);
        av_read = 1'b1; av_address = 8'h10; jtag_rd = 1'b1;
        av_lat = 99; jt_lat = 99; rd = '0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (i == 1) jtag_rd = 1'b0;
            if (av_lat == 99 && !av_waitrequest) begin
                av_lat = i; rd = av_readdata; av_read = 1'b0;
            end
            if (jtag_done) begin
                jt_lat = i;
                break;
            end
        end
        av_read = 1'b0;
        tick();
        check("rr1_av_lat", 32'(av_lat), 32'd3);
        check("rr1_jt_lat", 32'(jt_lat), 32'd7);
        check("rr1_av_data", rd, 32'hDEADBEEF);
        check("rr1_dreg", mon_dreg, 32'd1);

        // Avalon-only access makes last grant AV, then JTAG wins the tie
        av_access(1'b0, 8'hFF, 32'h0, 1'b0, lat, rd);
        check("rr2_pre_data", rd, 32'd2);
        jt_load(8'hFF);
        av_read = 1'b1; av_address = 8'h00; jtag_rd = 1'b1;
        av_lat = 99; jt_lat = 99; rd = '0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (i == 1) jtag_rd = 1'b0;
            if (jt_lat == 99 && jtag_done) jt_lat = i;
            if (av_lat == 99 && !av_waitrequest) begin
                av_lat = i; rd = av_readdata; av_read = 1'b0;
            end
            if (av_lat != 99 && jt_lat != 99) break;
        end
        av_read = 1'b0;
        tick();
        check("rr2_jt_lat", 32'(jt_lat), 32'd3);
        check("rr2_av_lat", 32'(av_lat), 32'd6);
        check("rr2_dreg", mon_dreg, 32'd2);
        check("rr2_av_data", rd, 32'd3);

        // Second write while pending: overrun, dropped
        jt_load(8'h20);
        w0 = wr_cnt;
        jtag_wr = 1'b1; jtag_wdata = 32'h0000AAAA;
        tick();
        jtag_wdata = 32'h0000BBBB;
        tick();
        jtag_wr = 1'b0;
        check("ovr_done", 32'(jtag_done), 32'd1);
        check("ovr_flag", 32'(jtag_overrun), 32'd1);
        tick();
        check("ovr_no_second_done", 32'(jtag_done), 32'd0);
        repeat (3) tick();
        check("ovr_sticky", 32'(jtag_overrun), 32'd1);
        check("ovr_mem", mem[8'h20], 32'h0000AAAA);
        check("ovr_wr_cnt", 32'(wr_cnt - w0), 32'd1);

        // Reset during RD_WAIT
        jt_load(8'h10);
        jtag_rd = 1'b1;
        tick();
        jtag_rd = 1'b0;
        check("rstmid_ram_rd", 32'(ram_rd), 32'd1);
        tick();
        #2 reset_n = 1'b0;
        #1;
        check("rstmid_waitreq", 32'(av_waitrequest), 32'd1);
        check("rstmid_done", 32'(jtag_done), 32'd0);
        check("rstmid_overrun", 32'(jtag_overrun), 32'd0);
        check("rstmid_dreg", mon_dreg, 32'd0);
        check("rstmid_areg", 32'(mon_areg), 32'd0);
        check("rstmid_ram_rd", 32'(ram_rd), 32'd0);
        check("rstmid_ram_addr", 32'(ram_addr), 32'd0);
        repeat (3) tick();
        check("rstmid_hold_done", 32'(jtag_done), 32'd0);
        reset_n = 1'b1;
        repeat (2) tick();
        check("rstrel_done", 32'(jtag_done), 32'd0);
        check("rstrel_overrun", 32'(jtag_overrun), 32'd0);
        jt_load(8'h10);
        jt_access(1'b0, 32'h0, lat);
        check("rstrel_jtr_lat", 32'(lat), 32'd3);
        check("rstrel_jtr_dreg", mon_dreg, 32'hDEADBEEF);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
